// File: rtl/writecontrol_lvl.sv
// Write-domain pointer/flag controller for the async FIFO: binary and Gray write pointers, full, almost-full, level.
// Optional sticky overflow detection is compiled in with the WR_OVF_DET_EN macro.
module writecontrol_lvl #(
    parameter int ptr_width = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic                 w_clk,
    input  logic                 wrst_n,
    input  logic                 w_en,
    input  logic [ptr_width-1:0] g_rptr_sync,
    output logic [ptr_width-1:0] b_wptr,
    output logic [ptr_width-1:0] g_wptr,
    output logic [ptr_width-2:0] waddr,
    output logic                 wr_accept,
    output logic                 full,
    output logic                 almost_full,
`ifdef WR_OVF_DET_EN
    input  logic                 clr_ovf,
    output logic                 overflow,
`endif
    output logic [ptr_width-1:0] wlevel
);

    localparam int DEPTH = 1 << (ptr_width - 1);
    localparam logic [ptr_width-1:0] AF_THRESH = ptr_width'(DEPTH - AF_MARGIN);

    logic [ptr_width-1:0] b_wptr_nxt;
    logic [ptr_width-1:0] g_wptr_nxt;
    logic [ptr_width-1:0] b_rptr_sync;
    logic [ptr_width-1:0] level_nxt;
    logic [ptr_width-1:0] full_cmp;
    logic                 full_nxt;
    logic                 af_nxt;

    function automatic logic [ptr_width-1:0] gray2bin(input logic [ptr_width-1:0] g);
        logic [ptr_width-1:0] b;
        b[ptr_width-1] = g[ptr_width-1];
        for (int i = ptr_width - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign wr_accept   = w_en & ~full;
    assign waddr       = b_wptr[ptr_width-2:0];
    assign b_wptr_nxt  = b_wptr + {{(ptr_width-1){1'b0}}, wr_accept};
    assign g_wptr_nxt  = (b_wptr_nxt >> 1) ^ b_wptr_nxt;
    assign b_rptr_sync = gray2bin(g_rptr_sync);
    assign level_nxt   = b_wptr_nxt - b_rptr_sync;

    // Full means the write pointer is exactly one lap ahead: in Gray code the top two bits differ, the rest match.
    assign full_cmp = {~g_rptr_sync[ptr_width-1:ptr_width-2], g_rptr_sync[ptr_width-3:0]};
    assign full_nxt = (g_wptr_nxt == full_cmp);
    assign af_nxt   = (level_nxt >= AF_THRESH);

    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            b_wptr      <= '0;
            g_wptr      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wlevel      <= '0;
        end else begin
            b_wptr      <= b_wptr_nxt;
            g_wptr      <= g_wptr_nxt;
            full        <= full_nxt;
            almost_full <= af_nxt;
            wlevel      <= level_nxt;
        end
    end

`ifdef WR_OVF_DET_EN
    // A new overflow in the same cycle as a clear keeps the flag set.
    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            overflow <= 1'b0;
        end else begin
            overflow <= (w_en & full) | (overflow & ~clr_ovf);
        end
    end
`endif

endmodule

// File: doc/writecontrol_lvl.md
Name: writecontrol_lvl

Overview:
- Write-side pointer and flag controller for the async FIFO, in the write clock domain.
- Pairs with the read-side controller. It produces the binary and Gray write pointers, the RAM write address, a registered full flag, an almost-full flag and a fill level.
- It consumes the read Gray pointer after the two-flop synchronizer has brought it into the w_clk domain.
- Its Gray pointer output feeds the read-domain synchronizer.

Parameters:
- ptr_width, 4: pointer width including the wrap bit. FIFO depth DEPTH = 2^(ptr_width-1). Address width is ptr_width-1.
- AF_MARGIN, 2: almost_full asserts when the level is at least DEPTH-AF_MARGIN. Legal range 1..DEPTH-1.

Ports:
- w_clk  input  1  write clock; all state updates on its rising edge
- wrst_n  input  1  asynchronous active-low reset
- w_en  input  1  write request from the producer
- g_rptr_sync  input  ptr_width  read Gray pointer, already synchronized to w_clk
- b_wptr  output  ptr_width  binary write pointer (registered)
- g_wptr  output  ptr_width  Gray write pointer (registered), to the read-domain synchronizer
- waddr  output  ptr_width-1  RAM write address, equal to b_wptr[ptr_width-2:0] (combinational)
- wr_accept  output  1  w_en & ~full (combinational); RAM write enable
- full  output  1  FIFO full (registered)
- almost_full  output  1  level is at least DEPTH-AF_MARGIN (registered)
- wlevel  output  ptr_width  occupied entries, 0..DEPTH (registered)
- clr_ovf  input  1  clears overflow; present only with WR_OVF_DET_EN
- overflow  output  1  sticky overflow flag; present only with WR_OVF_DET_EN

Behaviour:
- Reset: wrst_n low clears b_wptr, g_wptr, full, almost_full, wlevel and overflow to 0 immediately, with no clock edge needed. Release is synchronous to the next w_clk edge, and that first edge is already functional.
- Next-state pointers:
  - b_wptr_next = b_wptr + wr_accept, modulo 2^ptr_width.
  - g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next.
  - On each edge, b_wptr <= b_wptr_next and g_wptr <= g_wptr_next.
  - g_wptr changes at most one bit per cycle; it is never driven combinationally.
- Read pointer conversion: b_rptr_sync = Gray-to-binary of g_rptr_sync, computed combinationally as a prefix XOR from the MSB down.
- Full: full <= (g_wptr_next == {~g_rptr_sync[ptr_width-1:ptr_width-2], g_rptr_sync[ptr_width-3:0]}).
  - full asserts in the same cycle b_wptr reaches the full position. There is no extra write slot.
- Level: wlevel <= (b_wptr_next - b_rptr_sync), modulo 2^ptr_width.
- Almost-full: almost_full <= ((b_wptr_next - b_rptr_sync) >= DEPTH-AF_MARGIN).
- Latency: a write accepted at edge N is reflected in b_wptr, g_wptr, full, wlevel and almost_full after edge N.
- Read frees: a change on g_rptr_sync is reflected in full, wlevel and almost_full after the next edge. Full deassertion is therefore pessimistic by the synchronizer delay; this is intended.
- Write while full: wr_accept = 0, and the pointers, level and flags hold.
- Simultaneous write and g_rptr_sync advance: both are applied in the same cycle, so the level is unchanged and full is re-evaluated against the new read pointer.
- Wrap-around:
  - The binary pointer wraps from 2^ptr_width-1 to 0, and the Gray pointer wraps from its top code to 0.
  - The wrap bit distinguishes full from empty. No spurious full may occur across a wrap.
- g_rptr_sync is never used raw from the read domain; the synchronizer lives outside this block.

Optional Feature:
- Macro: WR_OVF_DET_EN.
- Defined:
  - Adds clr_ovf and overflow.
  - overflow sets on any edge where w_en & full, and stays set until an edge with clr_ovf = 1 and no new overflow.
  - If set and clear occur in the same cycle, set wins.
  - overflow resets to 0.
- Undefined: neither port exists, and a write while full is silently dropped with no other behavioural difference.

Test Plan (ptr_width=4, DEPTH=8, AF_MARGIN=2):
- Reset: assert wrst_n=0 mid-clock with no edge. Required: b_wptr=0, g_wptr=0, full=0, almost_full=0, wlevel=0 immediately.
- Fill: hold g_rptr_sync=0 and apply 8 back-to-back writes. Required: g_wptr steps 1,3,2,6,7,5,4,C; almost_full=1 once wlevel=6; after the 8th edge b_wptr=8, wlevel=8, full=1.
- Write while full: hold w_en=1 for 3 cycles at full. Required: wr_accept=0, b_wptr stays 8. With WR_OVF_DET_EN, overflow=1 from the first edge and stays set until clr_ovf pulses.
- Free one entry: set g_rptr_sync to 1 while full. Required: after the next edge full=0, wlevel=7. One further write restores full=1 and wlevel=8.
- Wrap: run 20 writes with g_rptr_sync tracking 2 cycles behind. Required: b_wptr passes 15→0 and g_wptr passes 8→0; full never asserts while wlevel<8; wlevel stays 0..8.
- Async reset mid-burst at wlevel=5. Required: all outputs are 0 without a clock edge, and the first write after release gives b_wptr=1, g_wptr=1.
